// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: synchronous reset, flush to NOP, load, else hold.
module if_id_reg #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc4_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc4_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc4_q;
  logic               valid_q;

  // Flush wins over load so a redirect always kills the in-flight slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: drives imem requests, next-PC selection and the IF/ID register,
// with a one-entry skid for decode stalls and a drain state for redirects.
//   state | meaning
//   FETCH | request outstanding at pc_in
//   HOLD  | response parked in skid, waiting for decode stall to clear
//   DRAIN | redirect seen mid-request, discarding the orphaned response
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_ld,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc4,
  output logic               if_id_valid
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]  skid_pc4_q, skid_pc4_d;
  logic [ADDR_W-1:0]  target_q, target_d;

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  nxt;
  logic               ld;
  logic               id_load, id_flush;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc4;

  assign pc_inc = pc_in + ADDR_W'(PC_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      target_q     <= target_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    target_d     = target_q;
    ld           = 1'b0;
    nxt          = pc_inc;
    id_load      = 1'b0;
    id_flush     = 1'b0;
    id_instr     = imem.imem_rdata;
    id_pc4       = pc_inc;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          id_flush     = 1'b1;
          skid_instr_d = NOP_INSTR;
          skid_pc4_d   = '0;
          if (imem.imem_ready) begin
            ld  = 1'b1;
            nxt = redirect_target;
          end else begin
            target_d = redirect_target;
            state_d  = DRAIN;
          end
        end else if (imem.imem_ready) begin
          if (!stall) begin
            id_load = 1'b1;
            ld      = 1'b1;
          end else begin
            skid_instr_d = imem.imem_rdata;
            skid_pc4_d   = pc_inc;
            state_d      = HOLD;
          end
        end else if (!stall) begin
          id_flush = 1'b1;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          id_flush     = 1'b1;
          skid_instr_d = NOP_INSTR;
          skid_pc4_d   = '0;
          ld           = 1'b1;
          nxt          = redirect_target;
          state_d      = FETCH;
        end else if (!stall) begin
          id_load  = 1'b1;
          id_instr = skid_instr_q;
          id_pc4   = skid_pc4_q;
          ld       = 1'b1;
          nxt      = skid_pc4_q;
          state_d  = FETCH;
        end
      end

      DRAIN: begin
        id_flush = 1'b1;
        if (redirect_valid) begin
          if (imem.imem_ready) begin
            ld      = 1'b1;
            nxt     = redirect_target;
            state_d = FETCH;
          end else begin
            target_d = redirect_target;
          end
        end else if (imem.imem_ready) begin
          ld      = 1'b1;
          nxt     = target_q;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  assign pc_ld          = ld & ~rst;
  assign pc_next        = {nxt[ADDR_W-1:2], 2'b00};
  assign imem.imem_req  = ~rst & (state_q != HOLD);
  assign imem.imem_addr = pc_in;

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load_i (id_load),
    .flush_i(id_flush),
    .instr_i(id_instr),
    .pc4_i  (id_pc4),
    .instr_o(if_id_instr),
    .pc4_o  (if_id_pc4),
    .valid_o(if_id_valid)
  );

endmodule
